// File: rtl/mux8x1_serializer.sv
// mux8x1_serializer: captures one WIDTH-bit word over a valid/ready handshake,
// then walks a select index across it and emits one bit per accepted beat.
// Optional feature macro: PARITY_EN appends an even-parity beat after the data
// beats and moves ser_last onto that beat.
module mux8x1_serializer #(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  // First and final select index of a word, depending on bit order.
  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(WIDTH-1) : '0;
  localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(WIDTH-1);

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic             at_end;

  assign at_end = (sel == SEL_END);

`ifdef PARITY_EN
  logic parity_q;

  // Sequencer: capture in IDLE, step sel on each accepted beat, parity beat last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_q   <= '0;
      sel      <= '0;
      parity_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word_q   <= in;
          sel      <= SEL_START;
          parity_q <= 1'b0;
          state    <= SHIFT;
        end
        SHIFT: if (ser_ready) begin
          parity_q <= parity_q ^ word_q[sel];
          if (at_end) state <= PAR;
          else        sel   <= MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1);
        end
        PAR: if (ser_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; everything holds while ser_ready is low.
  always_comb begin
    ser_out  = 1'b0;
    ser_last = 1'b0;
    case (state)
      SHIFT: ser_out = word_q[sel];
      PAR: begin
        ser_out  = parity_q;
        ser_last = 1'b1;
      end
      default: ;
    endcase
  end
`else
  // Sequencer: capture in IDLE, step sel on each accepted beat, back to IDLE at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      sel    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word_q <= in;
          sel    <= SEL_START;
          state  <= SHIFT;
        end
        SHIFT: if (ser_ready) begin
          if (at_end) state <= IDLE;
          else        sel   <= MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; the end-index beat carries ser_last.
  always_comb begin
    ser_out  = 1'b0;
    ser_last = 1'b0;
    if (state == SHIFT) begin
      ser_out  = word_q[sel];
      ser_last = at_end;
    end
  end
`endif

  assign in_ready  = (state == IDLE);
  assign ser_valid = (state != IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mux8x1_serializer.sv
// Bench for mux8x1_serializer: one LSB-first and one MSB-first instance, driven
// from a table of words with hand-computed emit order and parity, plus a
// hand-written mid-word reset sequence. Follows PARITY_EN if defined.
module tb_mux8x1_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       iv0, iv1, ser_ready;
  logic       ir0, sv0, so0, sl0, bz0;
  logic       ir1, sv1, so1, sl1, bz1;
  logic [2:0] sel0, sel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8x1_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in(din), .in_valid(iv0), .in_ready(ir0),
    .ser_ready(ser_ready), .ser_out(so0), .ser_valid(sv0), .ser_last(sl0),
    .sel(sel0), .busy(bz0)
  );

  mux8x1_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in(din), .in_valid(iv1), .in_ready(ir1),
    .ser_ready(ser_ready), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1),
    .sel(sel1), .busy(bz1)
  );

  // seq[i] is the i-th bit expected on ser_out; par is the even-parity bit.
  typedef struct {
    bit       d;
    bit [7:0] w;
    bit [7:0] seq;
    bit       par;
    int       stall_at;
    bit       busy_in;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input bit d, input string tag, input bit v, input bit o,
                          input logic [2:0] s, input bit l, input bit r);
    chk({tag, " ser_valid"}, d ? sv1 : sv0, v);
    chk({tag, " ser_out"},   d ? so1 : so0, o);
    chk({tag, " sel"},       d ? sel1 : sel0, s);
    chk({tag, " ser_last"},  d ? sl1 : sl0, l);
    chk({tag, " in_ready"},  d ? ir1 : ir0, r);
    chk({tag, " busy"},      d ? bz1 : bz0, v);
  endtask

  task automatic run_word(input vec_t t, input int k);
    logic [2:0] es;
    bit         el;
    string      tag;
    @(negedge clk);
    din = t.w; ser_ready = 1'b1;
    if (t.d) iv1 = 1'b1; else iv0 = 1'b1;
    chk($sformatf("v%0d idle in_ready", k), t.d ? ir1 : ir0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iv0 = 1'b0; iv1 = 1'b0; din = t.w;
      es  = t.d ? 3'(7 - i) : 3'(i);
`ifdef PARITY_EN
      el  = 1'b0;
`else
      el  = (i == 7);
`endif
      tag = $sformatf("v%0d beat%0d", k, i);
      chk_beat(t.d, tag, 1'b1, t.seq[i], es, el, 1'b0);
      if (t.busy_in && i == 2) begin
        din = 8'hFF;
        if (t.d) iv1 = 1'b1; else iv0 = 1'b1;
      end
      if (t.stall_at == i) begin
        ser_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk_beat(t.d, {tag, " stall"}, 1'b1, t.seq[i], es, el, 1'b0);
        end
        ser_ready = 1'b1;
      end
    end
`ifdef PARITY_EN
    @(negedge clk);
    tag = $sformatf("v%0d par", k);
    chk_beat(t.d, tag, 1'b1, t.par, t.d ? 3'd0 : 3'd7, 1'b1, 1'b0);
    if (t.stall_at >= 0) begin
      ser_ready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk_beat(t.d, {tag, " stall"}, 1'b1, t.par, t.d ? 3'd0 : 3'd7, 1'b1, 1'b0);
      end
      ser_ready = 1'b1;
    end
`endif
    @(negedge clk);
    chk_beat(t.d, $sformatf("v%0d done", k), 1'b0, 1'b0, t.d ? 3'd0 : 3'd7, 1'b0, 1'b1);
  endtask

  initial begin
    //            d     word   seq    par  stall busy_in
    vecs[0] = '{1'b0, 8'hB2, 8'hB2, 1'b0, -1, 1'b0};
    vecs[1] = '{1'b0, 8'hB2, 8'hB2, 1'b0,  4, 1'b0};
    vecs[2] = '{1'b0, 8'h5A, 8'h5A, 1'b0, -1, 1'b1};
    vecs[3] = '{1'b1, 8'hA5, 8'hA5, 1'b0, -1, 1'b0};
    vecs[4] = '{1'b1, 8'h0F, 8'hF0, 1'b0,  2, 1'b0};
    vecs[5] = '{1'b0, 8'h07, 8'h07, 1'b1, -1, 1'b0};
    vecs[6] = '{1'b0, 8'h03, 8'h03, 1'b0, -1, 1'b0};
    vecs[7] = '{1'b1, 8'h01, 8'h80, 1'b1,  6, 1'b0};

    rst = 1'b1; din = '0; iv0 = 1'b0; iv1 = 1'b0; ser_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_beat(1'b0, "reset d0", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk_beat(1'b1, "reset d1", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_word(vecs[k], k);

    // Mid-word async reset at bit 3: outputs drop immediately, nothing follows.
    @(negedge clk);
    din = 8'hB2; ser_ready = 1'b1; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre sel", sel0, 3'd3);
    chk("rst pre valid", sv0, 1'b1);
    rst = 1'b1;
    #1;
    chk_beat(1'b0, "rst mid", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("rst post valid", sv0, 1'b0);
      chk("rst post in_ready", ir0, 1'b1);
    end

    // A fresh word after reset still serializes normally.
    run_word(vecs[0], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
